// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for updown_counter_n and its prescaler
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Bits needed to hold 0..n-1, never less than one so a register always exists.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - divides enabled cycles by PRESCALE to produce count steps
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic step,
  output logic pre_last
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, reset, clr};
      assign pre_last  = 1'b1;
    end else begin : g_count
      localparam int PW = clog2_min1(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre;

      assign pre_last = (pre == LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pre <= '0;
        end else if (clr) begin
          pre <= '0;
        end else if (en) begin
          pre <= pre_last ? '0 : pre + PW'(1);
        end
      end
    end
  endgenerate

  assign step = en & pre_last;

endmodule

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - up/down modulo counter with prescaler and load; UPDOWN_COUNTER_SAT_EN selects saturation
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);

  logic             step;
  logic             pre_last;
  dir_t             dir;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_top;
  logic             at_bottom;
  logic             at_end;
  logic [WIDTH-1:0] stepped;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (load),
    .en       (en),
    .step     (step),
    .pre_last (pre_last)
  );

  assign dir       = up ? DIR_UP : DIR_DOWN;
  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_val};
  assign inc_ext   = count_ext + (WIDTH + 1)'(1);
  assign dec_ext   = count_ext - (WIDTH + 1)'(1);

  // The extra bit catches both the top boundary and the borrow out of zero.
  assign at_top    = (inc_ext > MAX_EXT);
  assign at_bottom = dec_ext[WIDTH];
  assign at_end    = (dir == DIR_UP) ? at_top : at_bottom;

  assign tc = at_end & en & pre_last;

  always_comb begin
    stepped = count;
`ifdef UPDOWN_COUNTER_SAT_EN
    if (at_end) begin
      stepped = count;
    end else if (dir == DIR_UP) begin
      stepped = inc_ext[WIDTH-1:0];
    end else begin
      stepped = dec_ext[WIDTH-1:0];
    end
`else
    if (dir == DIR_UP) begin
      stepped = at_top ? '0 : inc_ext[WIDTH-1:0];
    end else begin
      stepped = at_bottom ? MAX_EXT[WIDTH-1:0] : dec_ext[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= (load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
      wrap  <= 1'b0;
    end else if (step) begin
      count <= stepped;
      wrap  <= at_end;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule
